// File: rtl/imem_pkg.sv
// imem_pkg: shared FSM states, out-of-range fill word and index-width helper for imem_responder
package imem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  localparam logic [63:0] OOR_FILL = '0;
  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH x INST_W storage, sync write port, registered read-before-write read port
// ports: i_clk, i_rst (clears only the read register), wr_en/wr_idx/wr_data, rd_en/rd_idx -> rd_data
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int INST_W = 32,
  parameter int IDX_W  = idx_w(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [INST_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [INST_W-1:0] rd_data
);
  logic [INST_W-1:0] mem [DEPTH];
  always_ff @(posedge i_clk)
    if (wr_en) mem[wr_idx] <= wr_data;
  // separate non-blocking processes give old data on a same-index same-cycle write
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_idx];
endmodule

// File: rtl/imem_responder.sv
// imem_responder: fixed-latency instruction-memory responder; optional IMEM_ERR_EN adds o_err/o_drop_cnt
// ports: i_clk, i_rst (async high), i_i_valid_addr/i_i_addr request, o_i_valid_inst/o_i_inst response,
//        i_wr_en/i_wr_idx/i_wr_data preload; with IMEM_ERR_EN: o_err, o_drop_cnt
module imem_responder
  import imem_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int INST_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_i_valid_addr,
  input  logic [ADDR_W-1:0]          i_i_addr,
  output logic                       o_i_valid_inst,
  output logic [INST_W-1:0]          o_i_inst,
  input  logic                       i_wr_en,
  input  logic [$clog2(DEPTH)-1:0]   i_wr_idx,
  input  logic [INST_W-1:0]          i_wr_data
`ifdef IMEM_ERR_EN
  ,
  output logic                       o_err,
  output logic [7:0]                 o_drop_cnt
`endif
);
  localparam int IDX_W = idx_w(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [IDX_W-1:0] idx, in_idx, rd_idx;
  logic oor, in_oor, rd_oor, resp_oor, req, rd_en;
  logic [INST_W-1:0] rd_data;
  assign in_idx = i_i_addr[IDX_W+1:2];
  assign in_oor = |(i_i_addr >> (IDX_W + 2));
  assign req = i_i_valid_addr && state != WAIT;
  // a single-cycle latency reads straight from the incoming request
  assign rd_en  = LATENCY == 1 ? req : (state == WAIT && cnt == CW'(1));
  assign rd_idx = LATENCY == 1 ? in_idx : idx;
  assign rd_oor = LATENCY == 1 ? in_oor : oor;
  assign o_i_valid_inst = state == RESP;
  assign o_i_inst = resp_oor ? OOR_FILL[INST_W-1:0] : rd_data;
  imem_array #(.DEPTH(DEPTH), .INST_W(INST_W), .IDX_W(IDX_W)) u_array (
    .i_clk(i_clk), .i_rst(i_rst),
    .wr_en(i_wr_en), .wr_idx(i_wr_idx), .wr_data(i_wr_data),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data)
  );
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      oor <= 1'b0;
      resp_oor <= 1'b0;
    end else begin
      if (req) begin
        idx <= in_idx;
        oor <= in_oor;
        cnt <= CW'(LATENCY - 1);
        state <= LATENCY == 1 ? RESP : WAIT;
      end else if (state == WAIT) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) state <= RESP;
      end else state <= IDLE;
      if (rd_en) resp_oor <= rd_oor;
    end
`ifdef IMEM_ERR_EN
  logic mis, resp_err, drop;
  assign drop = state == WAIT && i_i_valid_addr;
  assign o_err = (state == RESP && resp_err) || drop;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      mis <= 1'b0;
      resp_err <= 1'b0;
      o_drop_cnt <= '0;
    end else begin
      if (req) mis <= |i_i_addr[1:0];
      if (rd_en) resp_err <= rd_oor | (LATENCY == 1 ? |i_i_addr[1:0] : mis);
      if (drop && o_drop_cnt != 8'hFF) o_drop_cnt <= o_drop_cnt + 8'd1;
    end
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = &{1'b0, i_i_addr[1:0]};
`endif
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed scoreboard bench for imem_responder (LATENCY=3, DEPTH=1024)
module tb_imem_responder;
  logic clk = 0, rst = 1, valid = 0, wr_en = 0;
  logic [63:0] addr = '0;
  logic [9:0] wr_idx = '0;
  logic [31:0] wr_data = '0, inst, last = '0;
  logic vout;
  int cyc = 0, nvec = 0, nfail = 0, ndrop = 0;
  typedef struct {int cyc; logic [31:0] data; logic err;} exp_t;
  exp_t q[$];
`ifdef IMEM_ERR_EN
  logic err;
  logic [7:0] drop_cnt;
`endif
  always #5 clk = ~clk;
  imem_responder dut (
    .i_clk(clk), .i_rst(rst), .i_i_valid_addr(valid), .i_i_addr(addr),
    .o_i_valid_inst(vout), .o_i_inst(inst),
    .i_wr_en(wr_en), .i_wr_idx(wr_idx), .i_wr_data(wr_data)
`ifdef IMEM_ERR_EN
    , .o_err(err), .o_drop_cnt(drop_cnt)
`endif
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s cycle %0d: observed %h expected %h", tag, cyc, got, exp);
    end
  endtask
  task automatic tick();
    exp_t e;
    bit ev;
    @(posedge clk);
    #1;
    cyc++;
    ev = q.size() > 0 && q[0].cyc == cyc;
    check("valid", {63'd0, vout}, {63'd0, ev});
    if (ev) begin
      e = q.pop_front();
      last = e.data;
`ifdef IMEM_ERR_EN
      check("err_resp", {63'd0, err}, {63'd0, e.err});
`endif
    end
    check("inst", {32'd0, inst}, {32'd0, last});
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic wr(input logic [9:0] i, input logic [31:0] d);
    wr_en = 1; wr_idx = i; wr_data = d;
    tick();
    wr_en = 0;
  endtask
  task automatic req(input logic [63:0] a, input logic [31:0] d, input logic e);
    valid = 1; addr = a;
    q.push_back('{cyc + 3, d, e});
    tick();
    valid = 0;
  endtask
  task automatic drop(input logic [63:0] a);
    valid = 1; addr = a;
    #1;
    ndrop++;
`ifdef IMEM_ERR_EN
    check("err_drop", {63'd0, err}, 64'd1);
`endif
    tick();
    valid = 0;
  endtask
  initial begin
    ticks(3);
    check("rst_valid", {63'd0, vout}, 64'd0);
    check("rst_inst", {32'd0, inst}, 64'd0);
    #1 rst = 0;
    wr(5, 32'h00A00093);
    wr(6, 32'h11111111);
    wr(7, 32'h00000013);
    wr(0, 32'hFFFFFFFF);
    wr(1023, 32'hCAFEF00D);
    while (cyc < 10) tick();
    req(64'h14, 32'h00A00093, 0);
    ticks(6);
    req(64'h14, 32'h00A00093, 0);
    drop(64'h18);
    ticks(4);
`ifdef IMEM_ERR_EN
    check("drop_cnt", {56'd0, drop_cnt}, 64'(ndrop));
`endif
    req(64'h14, 32'h00A00093, 0);
    ticks(2);
    req(64'h18, 32'h11111111, 0);
    ticks(5);
    req(64'h1_0000_0000, 32'h0, 1);
    ticks(4);
    req(64'hFFC, 32'hCAFEF00D, 0);
    ticks(3);
    req(64'h1000, 32'h0, 1);
    ticks(3);
    req(64'h15, 32'h00A00093, 1);
    ticks(3);
    req(64'h1C, 32'h00000013, 0);
    tick();
    wr(7, 32'hDEADBEEF);
    ticks(3);
    req(64'h1C, 32'hDEADBEEF, 0);
    ticks(4);
    valid = 1; addr = 64'h14;
    tick();
    valid = 0;
    rst = 1;
    #1;
    check("rst_mid_valid", {63'd0, vout}, 64'd0);
    check("rst_mid_inst", {32'd0, inst}, 64'd0);
    last = '0;
    ticks(2);
    #1 rst = 0;
    ticks(5);
`ifdef IMEM_ERR_EN
    check("drop_cnt_rst", {56'd0, drop_cnt}, 64'd0);
`endif
    req(64'h14, 32'h00A00093, 0);
    ticks(4);
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder at the far end of the fetch interface.
- Accepts the one-cycle address-valid pulse issued by the program counter and returns one instruction word with a one-cycle instruction-valid pulse after a fixed latency.
- Serves as the fetch-side memory model in core-level simulation.
- Contents are preloaded through a simple write port.

Parameters:
- ADDR_W, 64, width of the fetch byte address.
- INST_W, 32, instruction word width.
- DEPTH, 1024, number of instruction words (power of two, >=2).
- LATENCY, 3, cycles from request cycle to response cycle (>=1).

Ports:
- i_clk  in  1  clock, all state updates on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_i_valid_addr  in  1  fetch request pulse.
- i_i_addr  in  ADDR_W  fetch byte address, sampled when i_i_valid_addr=1.
- o_i_valid_inst  out  1  one-cycle response pulse.
- o_i_inst  out  INST_W  instruction word; holds its value between responses.
- i_wr_en  in  1  preload write enable.
- i_wr_idx  in  $clog2(DEPTH)  preload word index.
- i_wr_data  in  INST_W  preload data.

Behaviour:
- Reset (async, i_rst=1):
  - FSM to IDLE; o_i_valid_inst=0; o_i_inst=0; latency counter=0; latched index=0.
  - Array contents are NOT cleared.
  - Reset asserted mid-request aborts the request; no response is issued after release.
- Word index is i_i_addr[IDX_W+1:2], where IDX_W=$clog2(DEPTH).
  - addr[1:0] is ignored.
  - Out of range: any of addr[ADDR_W-1:IDX_W+2] nonzero. The response word is 0, with normal timing.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if i_i_valid_addr=1, latch index and range flag, load counter=LATENCY-1. Next state is RESP if LATENCY=1, else WAIT.
  - WAIT: decrement counter each cycle. When counter reaches 1, read the array, register o_i_inst, go to RESP.
  - RESP: o_i_valid_inst=1 for exactly this cycle. If i_i_valid_addr=1 in RESP, accept a new request as in IDLE (back-to-back). Otherwise go to IDLE.
- Timing: a request sampled in cycle c produces o_i_valid_inst=1 in cycle c+LATENCY. o_i_inst is valid in the same cycle and held afterwards.
- Busy: requests in WAIT, and in the intervening cycles, are ignored and dropped. No queueing.
- The LATENCY=1 path reads the array in the request cycle itself.
- Write/read same index, same cycle: the read returns old data (read-before-write). Writes in earlier cycles are visible.
- i_wr_en is legal in every state, including during a pending request.

Optional Feature:
- Macro IMEM_ERR_EN.
- Defined:
  - Adds output o_err (1 bit, reset 0).
  - o_err=1 in the response cycle if the request was out of range or misaligned (addr[1:0]!=0).
  - o_err also pulses for one cycle whenever a request arrives in WAIT (dropped request).
  - A sticky 8-bit saturating counter o_drop_cnt (reset 0) counts dropped requests.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Package imem_pkg holds:
  - the FSM state enum (IDLE=0, WAIT=1, RESP=2);
  - the out-of-range fill constant (all zeros);
  - a function computing IDX_W from DEPTH.
- One sub-module, imem_array: DEPTH x INST_W storage with one synchronous write port and one registered read port using read-before-write ordering.

Test Plan:
- Reset, preload word 5=0x00A00093, request addr 0x14 in cycle 10 (LATENCY=3) -> o_i_valid_inst=1 only in cycle 13, o_i_inst=0x00A00093, held after.
- Request addr 0x14, then a second request at 0x18 in cycle c+1 -> second is dropped, exactly one response pulse. With IMEM_ERR_EN: o_err pulse in c+1, o_drop_cnt=1.
- Request in the RESP cycle (back-to-back, LATENCY=3) -> responses in cycles c+3 and c+6, correct data for each.
- Request addr 0x1_0000_0000 -> response word 0 with normal timing. With IMEM_ERR_EN: o_err=1 in the response cycle.
- Write index 7=0xDEADBEEF in the same cycle as the array read of index 7 (old 0x13) -> response 0x13; a repeat request returns 0xDEADBEEF.
- Assert i_rst in cycle c+1 of a pending request -> o_i_valid_inst stays 0, o_i_inst=0, and preloaded contents are intact after release.
